seq_stage_ctrl: RTL and testbench
=================================

Name: seq_stage_ctrl

Overview:
- Multi-cycle control FSM for the sequential RISC-V core.
- Sequences the shared datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Generates the register-file, PC and IR write enables, the memory request strobes and the PC mux select.
- Sits beside the datapath inside seq_wrapper; handshakes with the instruction and data memories through req/ready pairs.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for ready before bus-error halt; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; leaves IDLE when 1
- opcode  in  7  instr[6:0] from IR
- branch_taken  in  1  datapath branch comparator result, valid in EXECUTE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (store)
- ir_we  out  1  latch fetched instruction
- rf_we  out  1  register-file write
- pc_we  out  1  PC update
- pc_sel  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 rs1+imm (JALR)
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6
- halted  out  1  1 in HALT
- illegal  out  1  sticky: halted on an unknown opcode
- bus_err  out  1  sticky: halted on a memory timeout
- cycle_cnt  out  CNT_W  cycles since leaving IDLE
- instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, any state): state=IDLE; timeout counter, illegal, bus_err and both counters cleared.
- Output timing:
  - All strobes are combinational decodes of the registered state plus inputs.
  - All strobes are 0 in IDLE and HALT.
  - pc_sel = 00 whenever pc_we=0.
- Recognised opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_we=1 in the same cycle, then DECODE.
- DECODE (1 cycle):
  - SYSTEM: go to HALT (ECALL/EBREAK halt the core).
  - Unrecognised opcode: illegal<=1, go to HALT.
  - Otherwise: go to EXECUTE.
- EXECUTE (1 cycle):
  - LOAD/STORE: go to MEMORY.
  - BRANCH: pc_we=1; pc_sel=01 if branch_taken else 00; go to FETCH. BRANCH retires here.
  - All others: go to WRITEBACK.
- MEMORY:
  - dmem_req=1; dmem_we=1 for STORE only.
  - On dmem_ready=1, STORE: pc_we=1, pc_sel=00, go to FETCH. STORE retires here.
  - On dmem_ready=1, LOAD: go to WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we=1 and pc_we=1.
  - pc_sel: 01 for JAL, 10 for JALR, 00 otherwise.
  - Go to FETCH.
- Latency without wait states:
  - R/I/U/J: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entering FETCH or MEMORY; increments each cycle the request is pending without ready.
  - When it reaches MEM_TIMEOUT with ready still 0: bus_err<=1, go to HALT.
  - ready arriving in the same cycle the limit is reached wins; no error is raised.
- HALT: absorbing state; exited only by reset. run is ignored.
- run deasserted mid-instruction has no effect; run is sampled only in IDLE.
- Reset asserted mid-memory-access drops the request immediately. No write enable may be asserted while reset=1.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle outside IDLE and HALT.
  - instret_cnt increments on every cycle with pc_we=1.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs tied to 0; no counter flops are synthesised.

Test Plan:
- Reset, run=1, OP-IMM with imem_ready tied 1 -> states 0,1,2,3,5,1; rf_we and pc_we high only in WRITEBACK, pc_sel=00; instret_cnt=1 (with SEQ_PERF_CNT_EN).
- LOAD, dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; then WRITEBACK with rf_we=1; 8 cycles total.
- BRANCH with branch_taken=1, then BRANCH with branch_taken=0 -> pc_we in EXECUTE with pc_sel=01 then 00; rf_we never asserted.
- JAL then JALR -> WRITEBACK pc_sel=01 then 10, rf_we=1 both times.
- Opcode 0000000 -> HALT after DECODE, illegal=1, halted=1, all strobes 0 for 20 further cycles with run=1.
- MEM_TIMEOUT=4, imem_ready held 0 -> bus_err=1 and HALT after 4 wait cycles; async reset mid-FETCH -> state=0 before the next clk edge.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - multi-cycle control FSM for the sequential RISC-V core
//
// Sequences the shared datapath through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK. It drives the IR/RF/PC write enables, the memory request strobes
// and the PC mux select. It handshakes with the instruction and data memories
// through req/ready pairs.
//
// Parameters:
//   MEM_TIMEOUT  max wait cycles for a memory ready before bus-error halt (0 = off)
//   CNT_W        width of the performance counters
//
// Optional feature: define SEQ_PERF_CNT_EN to build the cycle/instret counters;
// otherwise cycle_cnt and instret_cnt are tied to zero.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   run                  start request, sampled only in IDLE
//   opcode               instr[6:0] from the IR
//   branch_taken         branch comparator result, valid in EXECUTE
//   imem_ready           instruction memory data valid
//   dmem_ready           data memory access complete
//   imem_req, dmem_req   memory request strobes
//   dmem_we              data write (store)
//   ir_we, rf_we, pc_we  IR, register-file and PC write enables
//   pc_sel               00 PC+4, 01 PC+imm, 10 rs1+imm
//   state                IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 HALT=6
//   halted               1 in HALT
//   illegal, bus_err     sticky halt causes
//   cycle_cnt            cycles since leaving IDLE
//   instret_cnt          retired instructions

module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The wait counter never exceeds MEM_TIMEOUT-1: at that value the FSM
  // either proceeds (ready) or halts, and any state change clears it.
  localparam int              TO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int              TO_LIM   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LIM_V = TO_W'(TO_LIM);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            mem_wait;
  logic            set_illegal, set_bus_err;

  logic is_load, is_store, is_branch, is_jal, is_jalr, is_system, is_known;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_system = (opcode == OP_SYSTEM);
  assign is_known  = is_load || is_store || is_branch || is_jal || is_jalr || is_system ||
                     (opcode == OP_R) || (opcode == OP_IMM) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC);

  // Limit reached this cycle; ready in the same cycle still takes priority.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LIM_V);

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    mem_wait    = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    // Reset forces every strobe low even before the async clear has settled.
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (run) state_d = S_FETCH;
        end
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else begin
            mem_wait = 1'b1;
            if (timeout_hit) begin
              set_bus_err = 1'b1;
              state_d     = S_HALT;
            end
          end
        end
        S_DECODE: begin
          if (is_system) begin
            state_d = S_HALT;
          end else if (!is_known) begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store) begin
            state_d = S_MEMORY;
          end else if (is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready) begin
            if (is_store) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else begin
            mem_wait = 1'b1;
            if (timeout_hit) begin
              set_bus_err = 1'b1;
              state_d     = S_HALT;
            end
          end
        end
        S_WRITEBACK: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
          state_d = S_FETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      to_cnt  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      // Any state change clears the counter, which covers every entry into
      // FETCH or MEMORY (including MEMORY -> FETCH after a store).
      if (state_d != state_q) begin
        to_cnt <= '0;
      end else if (mem_wait) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_HALT)) cyc_q <= cyc_q + CNT_W'(1);
      if (pc_we) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - self-checking bench for seq_stage_ctrl
`timescale 1ns/1ps
module tb_seq_stage_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6;

  logic          clk, reset, run, branch_taken, imem_ready, dmem_ready;
  logic [6:0]    opcode;
  logic          imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, halted, illegal, bus_err;
  logic [1:0]    pc_sel;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  seq_stage_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .state(state), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {state[2:0], imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel[1:0], halted, illegal, bus_err}
  typedef struct {
    logic        run;
    logic        irdy;
    logic        drdy;
    logic        bt;
    logic [6:0]  op;
    logic [13:0] exp;
  } cyc_t;

  cyc_t     q[$];
  logic [2:0] st_log[$];
  int       n_tests, n_fail;
  int       m_cyc, m_ins;
  logic     m_run, m_illegal, m_bus;

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic known_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_SYS);
  endfunction

  // stb = {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we}
  task automatic push(input logic [2:0] st, input logic [6:0] op, input logic irdy,
                      input logic drdy, input logic bt, input logic [5:0] stb,
                      input logic [1:0] sel);
    cyc_t c;
    c.run  = m_run;
    c.irdy = irdy;
    c.drdy = drdy;
    c.bt   = bt;
    c.op   = op;
    c.exp  = {st, stb, sel, (st == ST_H), m_illegal, m_bus};
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle trace of one instruction, from its class and the
  // number of wait cycles each memory inserts.
  task automatic gen(input logic [6:0] op, input int iw, input int dw, input logic bt,
                     output int n);
    int  n0;
    logic st;
    n0 = q.size();
    for (int i = 0; i < iw && i < TO; i++) push(ST_F, op, 1'b0, 1'b1, bt, 6'b100000, 2'b00);
    if (iw >= TO) begin
      m_bus = 1'b1;
      n = q.size() - n0;
      return;
    end
    push(ST_F, op, 1'b1, 1'b1, bt, 6'b100100, 2'b00);
    push(ST_D, op, 1'b1, 1'b1, bt, 6'b000000, 2'b00);
    if (op == OP_SYS || !known_op(op)) begin
      if (!known_op(op)) m_illegal = 1'b1;
      n = q.size() - n0;
      return;
    end
    if (op == OP_BR) begin
      push(ST_E, op, 1'b1, 1'b1, bt, 6'b000001, bt ? 2'b01 : 2'b00);
      n = q.size() - n0;
      return;
    end
    push(ST_E, op, 1'b1, 1'b1, bt, 6'b000000, 2'b00);
    if (op == OP_LOAD || op == OP_STORE) begin
      st = (op == OP_STORE);
      for (int i = 0; i < dw && i < TO; i++)
        push(ST_M, op, 1'b1, 1'b0, bt, {1'b0, 1'b1, st, 3'b000}, 2'b00);
      if (dw >= TO) begin
        m_bus = 1'b1;
        n = q.size() - n0;
        return;
      end
      push(ST_M, op, 1'b1, 1'b1, bt, {1'b0, 1'b1, st, 2'b00, st}, 2'b00);
      if (st) begin
        n = q.size() - n0;
        return;
      end
    end
    push(ST_W, op, 1'b1, 1'b1, bt, 6'b000011,
         (op == OP_JAL) ? 2'b01 : ((op == OP_JALR) ? 2'b10 : 2'b00));
    n = q.size() - n0;
  endtask

  task automatic gen_halt(input int cycles);
    for (int i = 0; i < cycles; i++) push(ST_H, OP_IMM, 1'b1, 1'b1, 1'b1, 6'b000000, 2'b00);
  endtask

  task automatic play();
    cyc_t          c;
    logic [13:0]   act;
    logic [CW-1:0] ec, ei;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      run = c.run; imem_ready = c.irdy; dmem_ready = c.drdy;
      branch_taken = c.bt; opcode = c.op;
      #1;
      act = {state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel,
             halted, illegal, bus_err};
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL outputs @%0t st|imem,dmem,we,ir,rf,pc|sel|halt,ill,bus got %b expected %b",
                 $time, act, c.exp);
      end
`ifdef SEQ_PERF_CNT_EN
      ec = CW'(m_cyc);
      ei = CW'(m_ins);
`else
      ec = '0;
      ei = '0;
`endif
      n_tests++;
      if (cycle_cnt !== ec || instret_cnt !== ei) begin
        n_fail++;
        $display("FAIL counters @%0t got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                 $time, cycle_cnt, instret_cnt, ec, ei);
      end
      st_log.push_back(state);
      if (c.exp[13:11] != ST_IDLE && c.exp[13:11] != ST_H) m_cyc++;
      if (c.exp[5]) m_ins++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; reset = 1'b1;
    #1;
    n_tests++;
    if ({state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted,
         illegal, bus_err} !== 14'd0 || cycle_cnt !== '0 || instret_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d strobes=%b%b%b%b%b%b sel=%b h=%b ill=%b bus=%b cyc=%0d ins=%0d, expected all 0",
               state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted,
               illegal, bus_err, cycle_cnt, instret_cnt);
    end
    @(negedge clk);
    run = 1'b0; reset = 1'b0;
    m_illegal = 1'b0; m_bus = 1'b0; m_cyc = 0; m_ins = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] exp_states[5];
    n_tests = 0; n_fail = 0;
    m_cyc = 0; m_ins = 0; m_run = 1'b1; m_illegal = 1'b0; m_bus = 1'b0;
    reset = 1'b1; run = 1'b0; opcode = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // OP-IMM from IDLE with imem_ready tied high
    st_log.delete();
    m_run = 1'b1;
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    gen(OP_IMM, 0, 0, 1'b0, n);
    chk_int("lat_opimm", n, 4);
    play();
    exp_states[0] = 3'd0; exp_states[1] = 3'd1; exp_states[2] = 3'd2;
    exp_states[3] = 3'd3; exp_states[4] = 3'd5;
    chk_int("opimm_log_len", st_log.size(), 5);
    for (int i = 0; i < 5 && i < st_log.size(); i++)
      chk_int($sformatf("opimm_state%0d", i), int'(st_log[i]), int'(exp_states[i]));
    chk_int("model_instret_opimm", m_ins, 1);
    chk_int("model_cycles_opimm", m_cyc, 4);

    // Instruction mix; run dropped mid-flight must not matter
    gen(OP_LOAD, 0, 3, 1'b0, n);  chk_int("lat_load_w3", n, 8);
    m_run = 1'b0;
    gen(OP_BR, 0, 0, 1'b1, n);    chk_int("lat_branch", n, 3);
    gen(OP_BR, 0, 0, 1'b0, n);
    gen(OP_JAL, 0, 0, 1'b0, n);
    gen(OP_JALR, 1, 0, 1'b0, n);  chk_int("lat_jalr_w1", n, 5);
    gen(OP_STORE, 0, 0, 1'b0, n); chk_int("lat_store", n, 4);
    gen(OP_LOAD, 0, 0, 1'b0, n);  chk_int("lat_load", n, 5);
    gen(OP_R, 2, 0, 1'b0, n);
    gen(OP_LUI, 0, 0, 1'b1, n);
    gen(OP_AUIPC, 0, 0, 1'b1, n);
    gen(OP_STORE, 3, 2, 1'b0, n);
    gen(OP_LOAD, TO - 1, TO - 1, 1'b0, n); chk_int("lat_load_edge_waits", n, 11);
    m_run = 1'b1;
    gen(OP_SYS, 0, 0, 1'b0, n);
    gen_halt(5);
    play();
    chk_int("model_instret_mix", m_ins, 13);
    do_reset();

    // Unknown opcode: illegal halt, absorbing with run=1
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    gen(7'b0000000, 0, 0, 1'b0, n);
    gen_halt(20);
    play();
    chk_int("illegal_flag", int'(illegal), 1);
    chk_int("illegal_halted", int'(halted), 1);
    do_reset();

    // Fetch timeout
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    gen(OP_IMM, 10, 0, 1'b0, n);
    chk_int("lat_fetch_timeout", n, 4);
    gen_halt(6);
    play();
    chk_int("fetch_to_state", int'(state), 6);
    chk_int("fetch_to_bus_err", int'(bus_err), 1);
    do_reset();

    // Data memory timeout on a store
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    gen(OP_STORE, 0, 10, 1'b0, n);
    chk_int("lat_mem_timeout", n, 7);
    gen_halt(3);
    play();
    chk_int("mem_to_bus_err", int'(bus_err), 1);
    do_reset();

    // Async reset in the middle of a pending fetch
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    push(ST_F, OP_IMM, 1'b0, 1'b1, 1'b0, 6'b100000, 2'b00);
    push(ST_F, OP_IMM, 1'b0, 1'b1, 1'b0, 6'b100000, 2'b00);
    play();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_int("async_reset_state", int'(state), 0);
    chk_int("async_reset_imem_req", int'(imem_req), 0);
    @(negedge clk);
    run = 1'b0; reset = 1'b0;
    m_illegal = 1'b0; m_bus = 1'b0; m_cyc = 0; m_ins = 0;

    // Recovery after reset
    push(ST_IDLE, OP_IMM, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b00);
    gen(OP_JAL, 0, 0, 1'b0, n);
    play();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
